// File: rtl/accel_neuron_unit.sv
// rtl/accel_neuron_unit.sv - streaming multiply-accumulate neuron with shift, saturation and optional ReLU
module accel_neuron_unit #(
    parameter int MAX_PAIRS = 32,
    parameter int ACC_W     = 37
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        accel_en,
    input  logic        bus_wr,
    input  logic [15:0] bus_data_in,
    output logic [15:0] bus_data_out,
    output logic        accel_done,
    output logic        busy,
    output logic        bus_err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_IN    = 2'd1,
        S_WT    = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    localparam logic signed [ACC_W-1:0] C_SAT_MAX = ACC_W'(32767);
    localparam logic signed [ACC_W-1:0] C_SAT_MIN = ACC_W'(-32768);

    state_t                    r_state;
    logic [5:0]                r_cnt;
    logic [3:0]                r_shift;
    logic                      r_relu;
    logic signed [15:0]        r_x;
    logic signed [31:0]        r_prod;
    logic                      r_prod_vld;
    logic signed [ACC_W-1:0]   r_acc;
    logic [15:0]               r_result;
    logic                      r_res_vld;
    logic [15:0]               r_out;
    logic                      r_done;
    logic                      r_err;

    logic [5:0]                w_hdr_cnt;
    logic signed [31:0]        w_prod;
    logic signed [ACC_W-1:0]   w_shifted;
    logic [15:0]               w_sat;

    assign w_hdr_cnt = (bus_data_in[5:0] > 6'(MAX_PAIRS)) ? 6'(MAX_PAIRS) : bus_data_in[5:0];
    assign w_prod    = r_x * $signed(bus_data_in);
    assign w_shifted = r_acc >>> r_shift;

    always_comb begin
        w_sat = 16'(w_shifted);
        if (w_shifted > C_SAT_MAX) begin
            w_sat = 16'h7FFF;
        end else if (w_shifted < C_SAT_MIN) begin
            w_sat = 16'h8000;
        end
        if (r_relu && (w_shifted < 0)) begin
            w_sat = 16'h0000;
        end
    end

    // Everything freezes while accel_en is low, including a pending done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= 6'd0;
            r_shift    <= 4'd0;
            r_relu     <= 1'b0;
            r_x        <= 16'sd0;
            r_prod     <= 32'sd0;
            r_prod_vld <= 1'b0;
            r_acc      <= '0;
            r_result   <= 16'h0000;
            r_res_vld  <= 1'b0;
            r_out      <= 16'h0000;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else if (accel_en) begin
            r_done <= 1'b0;
            if (r_prod_vld) begin
                r_acc      <= r_acc + ACC_W'(r_prod);
                r_prod_vld <= 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    if (bus_wr) begin
                        r_cnt     <= w_hdr_cnt;
                        r_shift   <= bus_data_in[11:8];
                        r_relu    <= bus_data_in[15];
                        r_acc     <= '0;
                        r_err     <= 1'b0;
                        r_res_vld <= 1'b0;
                        r_state   <= (w_hdr_cnt == 6'd0) ? S_DRAIN : S_IN;
                    end
                end
                S_IN: begin
                    if (bus_wr) begin
                        r_x     <= $signed(bus_data_in);
                        r_state <= S_WT;
                    end
                end
                S_WT: begin
                    if (bus_wr) begin
                        r_prod     <= w_prod;
                        r_prod_vld <= 1'b1;
                        r_cnt      <= r_cnt - 6'd1;
                        r_state    <= (r_cnt == 6'd1) ? S_DRAIN : S_IN;
                    end
                end
                S_DRAIN: begin
                    if (bus_wr) begin
                        r_err <= 1'b1;
                    end
                    // Wait for the last product to land, then one cycle to shape, one to publish.
                    if (!r_prod_vld) begin
                        if (!r_res_vld) begin
                            r_result  <= w_sat;
                            r_res_vld <= 1'b1;
                        end else begin
                            r_out     <= r_result;
                            r_done    <= 1'b1;
                            r_res_vld <= 1'b0;
                            r_state   <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus_data_out = r_out;
    assign accel_done   = r_done & accel_en;
    assign busy         = (r_state != S_IDLE);
    assign bus_err      = r_err;

endmodule

// File: tb/tb_accel_neuron_unit.sv
// tb/tb_accel_neuron_unit.sv - self-checking bench for accel_neuron_unit against a transaction-level model
module tb_accel_neuron_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        accel_en = 1'b0;
    logic        bus_wr = 1'b0;
    logic [15:0] bus_data_in = 16'h0000;
    logic [15:0] bus_data_out;
    logic        accel_done;
    logic        busy;
    logic        bus_err;

    accel_neuron_unit #(.MAX_PAIRS(32), .ACC_W(37)) dut (
        .clk          (clk),
        .rst          (rst),
        .accel_en     (accel_en),
        .bus_wr       (bus_wr),
        .bus_data_in  (bus_data_in),
        .bus_data_out (bus_data_out),
        .accel_done   (accel_done),
        .busy         (busy),
        .bus_err      (bus_err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int done_cnt = 0;
    int last_wr_cyc = 0;
    int d_cyc = 0;
    logic [15:0] d_out = 16'h0000;
    bit rand_mode = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (accel_done) done_cnt <= done_cnt + 1;

    function automatic void chk(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic logic [15:0] f_res(input longint s, input int sh, input bit relu);
        longint r;
        r = s >>> sh;
        if (r > 32767) r = 32767;
        else if (r < -32768) r = -32768;
        if (relu && r < 0) r = 0;
        return r[15:0];
    endfunction

    // Transaction-level model: words in, pairs counted, done due a fixed number of enabled cycles later.
    bit          m_collect = 0, m_need_w = 0, m_done = 0, m_err = 0, m_relu = 0, m_draining = 0;
    int          m_left = 0, m_cd = 0, m_sh = 0, m_x = 0, m_n = 0;
    longint      m_sum = 0;
    logic [15:0] m_out = 16'h0000, m_pend = 16'h0000;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_collect = 0; m_need_w = 0; m_done = 0; m_err = 0; m_relu = 0;
            m_left = 0; m_cd = 0; m_sh = 0; m_x = 0; m_sum = 0;
            m_out = 16'h0000; m_pend = 16'h0000;
        end else if (accel_en) begin
            m_draining = (m_cd > 0);
            m_done = 0;
            if (m_cd > 0) begin
                m_cd--;
                if (m_cd == 0) begin
                    m_done = 1;
                    m_out = m_pend;
                end
            end
            if (bus_wr) begin
                if (m_draining) begin
                    m_err = 1;
                end else if (!m_collect) begin
                    m_n = int'(bus_data_in[5:0]);
                    if (m_n > 32) m_n = 32;
                    m_sh = int'(bus_data_in[11:8]);
                    m_relu = bus_data_in[15];
                    m_sum = 0;
                    m_err = 0;
                    if (m_n == 0) begin
                        m_cd = 2;
                        m_pend = 16'h0000;
                    end else begin
                        m_collect = 1;
                        m_need_w = 0;
                        m_left = m_n;
                    end
                end else if (!m_need_w) begin
                    m_x = int'($signed(bus_data_in));
                    m_need_w = 1;
                end else begin
                    m_sum += longint'(m_x) * longint'($signed(bus_data_in));
                    m_need_w = 0;
                    m_left--;
                    if (m_left == 0) begin
                        m_collect = 0;
                        m_cd = 3;
                        m_pend = f_res(m_sum, m_sh, m_relu);
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("accel_done", accel_done, longint'(m_done && accel_en));
        chk("bus_data_out", bus_data_out, m_out);
        chk("busy", busy, longint'(m_collect || (m_cd > 0)));
        chk("bus_err", bus_err, m_err);
    end

    task automatic step;
        @(posedge clk);
        #2;
    endtask

    task automatic wr(input logic [15:0] d);
        bus_wr = 1'b1;
        accel_en = 1'b1;
        bus_data_in = d;
        @(posedge clk);
        #1 last_wr_cyc = cyc;
        #1 bus_wr = 1'b0;
        bus_data_in = 16'($urandom);
    endtask

    task automatic pair(input int x, input int w);
        wr(16'(x));
        wr(16'(w));
    endtask

    task automatic gap;
        repeat ($urandom_range(0, 2)) begin
            accel_en = ($urandom_range(0, 2) != 0);
            bus_wr = !accel_en && ($urandom_range(0, 1) == 1);
            step;
        end
        bus_wr = 1'b0;
    endtask

    task automatic wait_done;
        int k;
        k = 0;
        #1;
        while (!accel_done && k < 300) begin
            step;
            if (rand_mode) accel_en = ($urandom_range(0, 3) != 0);
            #1;
            k++;
        end
        tests++;
        if (!accel_done) begin
            fails++;
            $display("FAIL done_timeout: accel_done=%0b after %0d cycles, required 1", accel_done, k);
        end
        d_cyc = cyc;
        d_out = bus_data_out;
    endtask

    function automatic int rand_val();
        if ($urandom_range(0, 3) == 0) return int'($signed(16'($urandom)));
        return $urandom_range(0, 600) - 300;
    endfunction

    int h_cyc, dc, n, sh, xv, wv;
    bit relu;
    longint s;
    logic [15:0] hdr;

    initial begin
        repeat (3) step;
        chk("reset_out", bus_data_out, 16'h0000);
        chk("reset_busy", busy, 0);
        rst = 1'b0;
        accel_en = 1'b1;
        step;

        wr(16'h0002); pair(3, 4); pair(-2, 5);
        wait_done;
        chk("lat_basic", d_cyc - last_wr_cyc, 3);
        chk("out_basic", d_out, 16'h0002);

        wr(16'h8001); pair(-3, 7);
        wait_done;
        chk("out_relu", d_out, 16'h0000);
        wr(16'h0001); pair(-3, 7);
        wait_done;
        chk("out_neg", d_out, 16'hFFEB);

        wr(16'h0002); pair(32767, 32767); pair(32767, 32767);
        wait_done;
        chk("out_sat", d_out, 16'h7FFF);
        wr(16'h0F01); pair(16384, 4);
        wait_done;
        chk("out_shift", d_out, 16'h0002);

        wr(16'h0000);
        h_cyc = last_wr_cyc;
        wait_done;
        chk("lat_zero", d_cyc - h_cyc, 2);
        chk("out_zero", d_out, 16'h0000);
        wr(16'h0001); pair(1, 1); wr(16'h1234);
        chk("err_set", bus_err, 1);
        wait_done;
        chk("out_err_run", d_out, 16'h0001);
        wr(16'h0000);
        chk("err_clear", bus_err, 0);
        wait_done;

        wr(16'h0001);
        h_cyc = last_wr_cyc;
        wr(16'd5);
        accel_en = 1'b0;
        repeat (5) begin
            bus_wr = 1'b1;
            bus_data_in = 16'($urandom);
            step;
        end
        bus_wr = 1'b0;
        wr(16'(-6));
        wait_done;
        chk("lat_frozen", d_cyc - h_cyc, 10);
        chk("out_frozen", d_out, 16'hFFE2);
        chk("err_frozen", bus_err, 0);

        wr(16'h0001); pair(2, 3);
        step; step; step;
        #1 chk("done_due", accel_done, 1);
        accel_en = 1'b0;
        #1 chk("done_gated", accel_done, 0);
        repeat (3) step;
        accel_en = 1'b1;
        wait_done;
        chk("lat_due_delay", d_cyc - last_wr_cyc, 6);
        chk("out_due_delay", d_out, 16'h0006);

        wr(16'h0002); pair(3, 3);
        step;
        rst = 1'b1;
        #1;
        chk("rst_out", bus_data_out, 16'h0000);
        chk("rst_busy", busy, 0);
        chk("rst_done", accel_done, 0);
        chk("rst_err", bus_err, 0);
        step;
        rst = 1'b0;
        dc = done_cnt;
        repeat (10) step;
        chk("rst_no_done", done_cnt - dc, 0);
        wr(16'h0001); pair(2, 2);
        wait_done;
        chk("out_after_rst", d_out, 16'h0004);

        rand_mode = 1'b1;
        repeat (60) begin
            n = $urandom_range(0, 40);
            sh = $urandom_range(0, 15);
            relu = ($urandom_range(0, 1) == 1);
            hdr = {relu, 3'($urandom), 4'(sh), 2'($urandom), 6'(n)};
            if (n > 32) n = 32;
            s = 0;
            gap;
            wr(hdr);
            for (int i = 0; i < n; i++) begin
                xv = rand_val();
                wv = rand_val();
                gap;
                wr(16'(xv));
                gap;
                wr(16'(wv));
                s += longint'(xv) * longint'(wv);
            end
            if ($urandom_range(0, 3) == 0) wr(16'($urandom));
            wait_done;
            chk("rand_out", d_out, f_res(s, sh, relu));
        end
        rand_mode = 1'b0;
        accel_en = 1'b1;
        step;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/accel_neuron_unit.md
ACCEL_NEURON_UNIT -- requirements
Module: accel_neuron_unit

Interface
REQ-001 SHALL have parameter MAX_PAIRS, default 32, giving the maximum input/weight pairs per neuron.
REQ-002 SHALL have parameter ACC_W, default 37, giving the signed accumulator width.
REQ-003 SHALL have port clk, input, 1 bit, the single clock.
REQ-004 SHALL have port rst, input, 1 bit, asynchronous active-high reset.
REQ-005 SHALL have port accel_en, input, 1 bit, enable; when 0 the unit is frozen.
REQ-006 SHALL have port bus_wr, input, 1 bit, CPU bus write strobe, one word per cycle it is high.
REQ-007 SHALL have port bus_data_in, input, 16 bits, CPU write data.
REQ-008 SHALL have port bus_data_out, output, 16 bits, neuron result to the CPU.
REQ-009 SHALL have port accel_done, output, 1 bit, single-cycle result-valid pulse.
REQ-010 SHALL have port busy, output, 1 bit, high in every state except IDLE.
REQ-011 SHALL have port bus_err, output, 1 bit, sticky protocol-error flag.

Function
REQ-012 SHALL implement states IDLE, IN, WT and DRAIN.
REQ-013 SHALL, in IDLE on bus_wr&accel_en, accept a header word: count=data[5:0], shift=data[11:8], relu=data[15], other bits ignored.
REQ-014 SHALL, on header accept, clear the accumulator and bus_err; count values 33..63 SHALL be treated as MAX_PAIRS.
REQ-015 SHALL, for header count 0, go to DRAIN with no pairs and finish with result 0x0000.
REQ-016 SHALL, for header count >0, go to IN.
REQ-017 SHALL, in IN on bus_wr, latch x=bus_data_in (signed) and go to WT.
REQ-018 SHALL, in WT on bus_wr, latch w and register the product x*w (signed 32-bit) on that edge.
REQ-019 SHALL, on the WT write, decrement the remaining count and go to DRAIN if it reaches 0, else to IN.
REQ-020 SHALL add the registered product into the sign-extended ACC_W accumulator on the following edge; the accumulator SHALL NOT overflow for any legal input.
REQ-021 SHALL, in DRAIN once the pipeline is empty, compute result = acc >>> shift (arithmetic).
REQ-022 SHALL saturate the result to [-32768, 32767]; if relu=1, negative results SHALL become 0.
REQ-023 SHALL register the result onto bus_data_out and return to IDLE.
REQ-024 SHALL assert accel_done high for exactly one cycle, 3 clocks after the edge that sampled the final weight write (2 clocks after header accept for count 0).
REQ-025 SHALL align the accel_done cycle with the first IDLE cycle.
REQ-026 SHALL hold bus_data_out stable from accel_done until the next result is registered.
REQ-027 SHALL accept a header write sampled in the same cycle that accel_done is high.
REQ-028 SHALL, when accel_en=0, ignore bus_wr without flagging an error and hold state, counters, product register and accumulator; accel_done SHALL NOT assert.
REQ-029 SHALL, when accel_en=0 in the cycle accel_done is due, delay the accel_done pulse to the first cycle accel_en=1.
REQ-030 SHALL, on bus_wr&accel_en in DRAIN, ignore the word and set bus_err; bus_err SHALL clear only on header accept or reset.

Reset
REQ-031 SHALL, while rst is high, force state IDLE, accumulator 0, product register 0, counters 0, bus_data_out 0x0000, accel_done 0, busy 0 and bus_err 0.
REQ-032 SHALL, when rst asserts mid-operation, abort the operation and produce no accel_done.
REQ-033 SHALL, after rst deasserts, require a new header before any pair is accepted.

Verification
REQ-034 SHALL cover: header 0x0002, pairs (3,4),(-2,5) -> accel_done 3 cycles after the last write, bus_data_out=0x0002.
REQ-035 SHALL cover: header 0x8001, pair (-3,7) -> bus_data_out=0x0000; repeat with header 0x0001 -> bus_data_out=0xFFEB.
REQ-036 SHALL cover: header 0x0002, pairs (0x7FFF,0x7FFF)x2 -> bus_data_out=0x7FFF; header 0x0F01, pair (0x4000,0x0004) -> bus_data_out=0x0002.
REQ-037 SHALL cover: header 0x0000 -> accel_done 2 cycles after accept, bus_data_out=0x0000; a bus_wr issued in DRAIN -> bus_err=1, cleared by the next header.
REQ-038 SHALL cover: accel_en=0 for 5 cycles between x and w with bus_wr pulses -> result unchanged, accel_done delayed 5 cycles, bus_err=0.
REQ-039 SHALL cover: rst pulsed after 1 of 2 pairs -> all outputs 0, no accel_done; a new header 0x0001 with pair (2,2) -> bus_data_out=0x0004.
